// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and helpers for the unified instruction/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package arb_pkg;

  localparam int ARB_MEM_AW_DEF = 6;

  // Which requester owns an access (grant) or a pending response.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

  // Byte address to word index: drop the byte offset, keep the low aw bits.
  // Higher address bits are discarded so accesses wrap around the memory.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned aw);
    return (addr >> 2) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold *_req until the matching *_gnt.
interface unified_mem_arbiter_if
  import arb_pkg::*;
#(
  parameter int MEM_AW = ARB_MEM_AW_DEF
);
  // fetch port
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [31:0]       if_rdata;
  // data port
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [3:0]        d_wstrb;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [31:0]       d_rdata;
  // memory port
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_wstrb;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_rdata,
    input  d_req, d_we, d_addr, d_wstrb, d_wdata,
    output d_gnt, d_valid, d_rdata,
    output mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Pipeline plus memory view.
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_rdata,
    output d_req, d_we, d_addr, d_wstrb, d_wdata,
    input  d_gnt, d_valid, d_rdata,
    input  mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/unified_mem_arbiter_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects inc one cycle later.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step only when asked and not already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one sync-read memory between fetch and load/store, one access per cycle.
// Latency: grant same cycle (combinational), read data / store ack one cycle later.
// Backpressure: a requester without gnt holds req; under contention data and fetch alternate.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_AW = ARB_MEM_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]      conflict_cnt
);

  gnt_e        last_q, last_d;
  gnt_e        resp_q, resp_d;
  logic        if_gnt_c;
  logic        d_gnt_c;
  logic        both_req;
  logic [31:0] sel_idx;

  assign both_req = bus.if_req & bus.d_req;

  // Arbitration: data normally wins; fetch wins a tie only right after a data grant.
  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (!rst) begin
      if (bus.d_req && !(bus.if_req && (last_q == GNT_D))) begin
        d_gnt_c = 1'b1;
      end else if (bus.if_req) begin
        if_gnt_c = 1'b1;
      end
    end
  end

  // Next state: remember the last owner, and who gets the response next cycle.
  always_comb begin
    last_d = last_q;
    resp_d = GNT_NONE;
    if (d_gnt_c) begin
      last_d = GNT_D;
      resp_d = GNT_D;
    end else if (if_gnt_c) begin
      last_d = GNT_IF;
      resp_d = GNT_IF;
    end
  end

  // Grant history and response tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_NONE;
      resp_q <= GNT_NONE;
    end else begin
      last_q <= last_d;
      resp_q <= resp_d;
    end
  end

  assign sel_idx = d_gnt_c ? word_index(bus.d_addr, MEM_AW) : word_index(bus.if_addr, MEM_AW);

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.mem_en    = if_gnt_c | d_gnt_c;
  assign bus.mem_we    = d_gnt_c & bus.d_we;
  assign bus.mem_wstrb = (d_gnt_c && bus.d_we) ? bus.d_wstrb : 4'b0000;
  assign bus.mem_addr  = sel_idx[MEM_AW-1:0];
  assign bus.mem_wdata = bus.d_wdata;

  // Reset in the response cycle squashes the valid; the access itself already happened.
  assign bus.if_valid = (resp_q == GNT_IF) && !rst;
  assign bus.d_valid  = (resp_q == GNT_D) && !rst;
  assign bus.if_rdata = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

  sat_counter #(.W(CNT_W)) u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (both_req),
    .count (conflict_cnt)
  );

endmodule
